// File: rtl/div_arb_pkg.sv
// Shared types and the grant picker used by the divider request arbiter.
package div_arb_pkg;

  localparam int unsigned DIV_W_DEFAULT = 16;
  localparam int unsigned ARB_MAX_REQ   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } div_arb_state_t;

  // One-hot grant: first set bit of req[n-1:0], searching upward from ptr and wrapping.
  function automatic logic [ARB_MAX_REQ-1:0] rr_pick(input logic [ARB_MAX_REQ-1:0] req,
                                                      input logic [2:0] ptr,
                                                      input logic [3:0] n);
    logic [ARB_MAX_REQ-1:0] gnt;
    logic [3:0]             idx;
    logic                   found;
    gnt   = '0;
    found = 1'b0;
    for (int k = 0; k < int'(ARB_MAX_REQ); k++) begin
      idx = 4'(ptr) + 4'(k);
      if (idx >= n) idx = idx - n;
      if ((4'(k) < n) && !found && req[idx[2:0]]) begin
        gnt[idx[2:0]] = 1'b1;
        found         = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/div_iter_core.sv
// Iterative restoring divider: one shift/compare/subtract step per cycle for W cycles.
// quot/rem present the result of the step in progress; they are final while step_done is high.
module div_iter_core
  import div_arb_pkg::*;
#(
  parameter int unsigned W = DIV_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         step_done,
  output logic [W-1:0] quot,
  output logic [W-1:0] rem
);

  localparam int unsigned CW = $clog2(W + 1);

  logic          active_q;
  logic [CW-1:0] cnt_q;
  logic [W:0]    rem_q;
  logic [W-1:0]  quot_q;
  logic [W-1:0]  dvs_q;

  logic [W+1:0]  diff;
  logic          qbit;
  logic [W:0]    rem_n;
  logic [W-1:0]  quot_n;

  // Shift the next dividend bit into the partial remainder and try the subtract.
  always_comb begin
    diff   = {rem_q, quot_q[W-1]} - {2'b00, dvs_q};
    qbit   = ~diff[W+1];
    rem_n  = qbit ? diff[W:0] : {rem_q[W-1:0], quot_q[W-1]};
    quot_n = {quot_q[W-2:0], qbit};
  end

  assign step_done = active_q && (cnt_q == CW'(W - 1));
  assign quot      = quot_n;
  assign rem       = rem_n[W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      rem_q    <= '0;
      quot_q   <= '0;
      dvs_q    <= '0;
    end else if (start) begin
      active_q <= 1'b1;
      cnt_q    <= '0;
      rem_q    <= '0;
      quot_q   <= dividend;
      dvs_q    <= divisor;
    end else if (active_q) begin
      rem_q    <= rem_n;
      quot_q   <= quot_n;
      cnt_q    <= cnt_q + CW'(1);
      if (step_done) active_q <= 1'b0;
    end
  end

endmodule

// File: rtl/div_req_arbiter.sv
// Shares one iterative divider among N_REQ requesters, one operation outstanding at a time.
// DIV_ARB_RR_EN defined: round-robin grant; undefined: fixed priority, lowest index wins.
module div_req_arbiter
  import div_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned W     = DIV_W_DEFAULT,
  parameter int unsigned IDW   = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*W-1:0] req_dividend,
  input  logic [N_REQ*W-1:0] req_divisor,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IDW-1:0]     rsp_id,
  output logic [W-1:0]       rsp_quot,
  output logic [W-1:0]       rsp_rem,
  output logic               rsp_err,
  output logic               busy
);

  div_arb_state_t         state_q, state_d;
  logic [ARB_MAX_REQ-1:0] grant_full;
  logic [N_REQ-1:0]       grant;
  logic [IDW-1:0]         gid;
  logic [W-1:0]           sel_dvd, sel_dvs;
  logic                   accept;
  logic                   core_start;
  logic                   core_done;
  logic [W-1:0]           core_quot, core_rem;
  logic [IDW-1:0]         id_q, id_d;
  logic                   rsp_valid_d, rsp_err_d, busy_d;
  logic [IDW-1:0]         rsp_id_d;
  logic [W-1:0]           rsp_quot_d, rsp_rem_d;
  logic                   unused_grant_bits;

`ifdef DIV_ARB_RR_EN
  logic [IDW-1:0] ptr_q;

  assign grant_full = rr_pick(8'(req_valid), 3'(ptr_q), 4'(N_REQ));

  // Search resumes just past the last accepted requester.
  always_ff @(posedge clk) begin
    if (rst)         ptr_q <= '0;
    else if (accept) ptr_q <= (gid == IDW'(N_REQ - 1)) ? '0 : gid + IDW'(1);
  end
`else
  assign grant_full = rr_pick(8'(req_valid), 3'd0, 4'(N_REQ));
`endif

  assign grant             = grant_full[N_REQ-1:0];
  assign unused_grant_bits = ^grant_full;

  // Index and operands of the granted requester.
  always_comb begin
    gid     = '0;
    sel_dvd = '0;
    sel_dvs = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        gid     = IDW'(i);
        sel_dvd = req_dividend[i*W +: W];
        sel_dvs = req_divisor[i*W +: W];
      end
    end
  end

  div_iter_core #(.W(W)) u_core (
    .clk       (clk),
    .rst       (rst),
    .start     (core_start),
    .dividend  (sel_dvd),
    .divisor   (sel_dvs),
    .step_done (core_done),
    .quot      (core_quot),
    .rem       (core_rem)
  );

  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    rsp_valid_d = rsp_valid;
    rsp_id_d    = rsp_id;
    rsp_quot_d  = rsp_quot;
    rsp_rem_d   = rsp_rem;
    rsp_err_d   = rsp_err;
    req_ready   = '0;
    accept      = 1'b0;
    core_start  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rst) req_ready = grant;
        accept = |(req_valid & req_ready);
        if (accept) begin
          id_d = gid;
          if (sel_dvs == '0) begin
            // Divide-by-zero is answered directly without running the core.
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_id_d    = gid;
            rsp_quot_d  = '1;
            rsp_rem_d   = sel_dvd;
            rsp_err_d   = 1'b1;
          end else begin
            state_d    = RUN;
            core_start = 1'b1;
          end
        end
      end
      RUN: begin
        if (core_done) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_id_d    = id_q;
          rsp_quot_d  = core_quot;
          rsp_rem_d   = core_rem;
          rsp_err_d   = 1'b0;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      id_q      <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_quot  <= '0;
      rsp_rem   <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      rsp_valid <= rsp_valid_d;
      rsp_id    <= rsp_id_d;
      rsp_quot  <= rsp_quot_d;
      rsp_rem   <= rsp_rem_d;
      rsp_err   <= rsp_err_d;
      busy      <= busy_d;
    end
  end

endmodule
